// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order queue of branch predictions issued at fetch. Each entry is paired
// with its outcome from execute, which then drives predictor training and,
// on a mispredict, a fetch redirect. Hit and total-branch counters are kept.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   pred_*              prediction push from fetch; pred_ready = not full
//   res_*               resolution of the oldest entry from execute
//   flush               discard all entries (a same-cycle resolve still counts)
//   upd_*               predictor training interface (upd_valid is a pulse)
//   redirect_*          corrected fetch PC on mispredict (pulse)
//   count               occupancy
//   hit_cnt, total_cnt  correctly predicted / resolved branches (wrap at 2^32)
//   underflow           sticky flag: resolve arrived while the queue was empty
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             flush,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      total_cnt,
  output logic             underflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic        push_ok, res_ok, empty_res, mispredict, clear_q;
  logic [31:0] head_pc, head_target;
  logic        head_taken;

  // Ready comes straight from the registered count, so a pop in the same
  // cycle never frees a slot for a push.
  assign pred_ready  = (count != FULL_CNT);
  assign push_ok     = pred_valid & pred_ready;
  assign res_ok      = res_valid & (count != '0);
  assign empty_res   = res_valid & (count == '0);

  assign head_pc     = pc_mem[rd_ptr];
  assign head_taken  = taken_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];

  assign mispredict  = res_ok & ((res_taken != head_taken) |
                                 (res_taken & (res_target != head_target)));
  // Everything younger than a mispredicted branch is wrong-path.
  assign clear_q     = flush | mispredict;

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]     <= pred_pc;
      taken_mem[wr_ptr]  <= pred_taken;
      target_mem[wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      hit_cnt        <= '0;
      total_cnt      <= '0;
      underflow      <= 1'b0;
    end else begin
      if (clear_q) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (res_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, res_ok})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      upd_valid      <= res_ok;
      redirect_valid <= mispredict;
      if (res_ok) begin
        upd_pc    <= head_pc;
        upd_taken <= res_taken;
        total_cnt <= total_cnt + 32'd1;
        if (!mispredict) hit_cnt <= hit_cnt + 32'd1;
      end
      if (mispredict)
        redirect_pc <= res_taken ? res_target : (head_pc + 32'd4);

      if (empty_res) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken, flush;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        pred_ready, upd_valid, upd_taken, redirect_valid, underflow;
  logic [31:0] upd_pc, redirect_pc, hit_cnt, total_cnt;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .hit_cnt(hit_cnt), .total_cnt(total_cnt),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set 1 time unit after a rising edge; tick advances one cycle,
  // leaves outputs ready to sample, and drops the single-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tg;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tg);
    res_valid  = 1'b1;
    res_taken  = tk;
    res_target = tg;
  endtask

  initial begin
    rst = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(pred_ready), 1);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_redirect", 32'(redirect_valid), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_total", total_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: fill to full, fifth push refused
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(4 * i), 1'b0, 32'h900);
      tick();
    end
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(pred_ready), 0);
    set_push(32'h110, 1'b0, 32'h900);
    tick();
    check("push_when_full", 32'(count), 4);

    // 2: correct not-taken resolve
    set_res(1'b0, 32'h0);
    tick();
    check("r1_upd_valid", 32'(upd_valid), 1);
    check("r1_upd_pc", upd_pc, 32'h100);
    check("r1_upd_taken", 32'(upd_taken), 0);
    check("r1_redirect", 32'(redirect_valid), 0);
    check("r1_hit", hit_cnt, 1);
    check("r1_total", total_cnt, 1);
    check("r1_count", 32'(count), 3);

    // 3: direction mispredict clears the queue
    set_res(1'b1, 32'h200);
    tick();
    check("r2_upd_pc", upd_pc, 32'h104);
    check("r2_upd_taken", 32'(upd_taken), 1);
    check("r2_redirect", 32'(redirect_valid), 1);
    check("r2_redirect_pc", redirect_pc, 32'h200);
    check("r2_count", 32'(count), 0);
    check("r2_hit", hit_cnt, 1);
    check("r2_total", total_cnt, 2);
    tick();
    check("pulse_upd_valid", 32'(upd_valid), 0);
    check("pulse_redirect", 32'(redirect_valid), 0);
    check("hold_upd_pc", upd_pc, 32'h104);

    // 4: predicted taken, actually not taken -> fall-through pc+4
    set_push(32'h300, 1'b1, 32'h400);
    tick();
    set_res(1'b0, 32'h0);
    tick();
    check("nt_redirect", 32'(redirect_valid), 1);
    check("nt_redirect_pc", redirect_pc, 32'h304);
    check("nt_total", total_cnt, 3);
    // taken both ways but wrong target
    set_push(32'h300, 1'b1, 32'h400);
    tick();
    set_res(1'b1, 32'h404);
    tick();
    check("tgt_redirect", 32'(redirect_valid), 1);
    check("tgt_redirect_pc", redirect_pc, 32'h404);
    check("tgt_hit", hit_cnt, 1);
    check("tgt_total", total_cnt, 4);
    // correct taken with matching target
    set_push(32'h500, 1'b1, 32'h600);
    tick();
    set_res(1'b1, 32'h600);
    tick();
    check("tk_redirect", 32'(redirect_valid), 0);
    check("tk_upd_taken", 32'(upd_taken), 1);
    check("tk_hit", hit_cnt, 2);
    check("tk_total", total_cnt, 5);

    // 5: empty resolve sets sticky underflow
    set_res(1'b0, 32'h0);
    tick();
    check("emp_upd_valid", 32'(upd_valid), 0);
    check("emp_total", total_cnt, 5);
    check("emp_underflow", 32'(underflow), 1);
    tick();
    check("emp_sticky", 32'(underflow), 1);
    // flush alone with two entries
    set_push(32'h700, 1'b0, 32'h0);
    tick();
    set_push(32'h704, 1'b0, 32'h0);
    tick();
    check("pre_flush_count", 32'(count), 2);
    flush = 1'b1;
    tick();
    check("flush_count", 32'(count), 0);
    check("flush_upd_valid", 32'(upd_valid), 0);
    check("flush_redirect", 32'(redirect_valid), 0);
    // flush beats a same-cycle push
    set_push(32'h720, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    check("flush_push_count", 32'(count), 0);
    // flush with resolve: resolution still counted
    set_push(32'h800, 1'b0, 32'h0);
    tick();
    set_res(1'b0, 32'h0);
    flush = 1'b1;
    tick();
    check("fr_upd_valid", 32'(upd_valid), 1);
    check("fr_upd_pc", upd_pc, 32'h800);
    check("fr_hit", hit_cnt, 3);
    check("fr_total", total_cnt, 6);
    check("fr_count", 32'(count), 0);
    // push into empty plus resolve: resolve ignored, push kept
    set_push(32'h900, 1'b0, 32'h0);
    set_res(1'b0, 32'h0);
    tick();
    check("pe_count", 32'(count), 1);
    check("pe_upd_valid", 32'(upd_valid), 0);
    check("pe_total", total_cnt, 6);
    set_res(1'b0, 32'h0);
    tick();
    check("pe_pop_pc", upd_pc, 32'h900);
    check("pe_hit", hit_cnt, 4);
    // full: push refused even with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      set_push(32'hA00 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    set_push(32'hA10, 1'b0, 32'h0);
    set_res(1'b0, 32'h0);
    tick();
    check("fullpop_count", 32'(count), 3);
    check("fullpop_upd_pc", upd_pc, 32'hA00);
    check("fullpop_total", total_cnt, 8);
    flush = 1'b1;
    tick();

    // 6: steady push+resolve at occupancy 2, pointers wrap
    set_push(32'hB00, 1'b0, 32'h0);
    tick();
    set_push(32'hB04, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_push(32'hB08 + 32'(4 * i), 1'b0, 32'h0);
      set_res(1'b0, 32'h0);
      tick();
      check($sformatf("stream_upd_pc_%0d", i), upd_pc, 32'hB00 + 32'(4 * i));
      check($sformatf("stream_count_%0d", i), 32'(count), 2);
    end
    check("stream_hit", hit_cnt, 15);
    check("stream_total", total_cnt, 18);

    // asynchronous reset mid-stream
    set_push(32'hC00, 1'b0, 32'h0);
    set_res(1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_upd_valid", 32'(upd_valid), 0);
    check("arst_upd_pc", upd_pc, 0);
    check("arst_redirect_pc", redirect_pc, 0);
    check("arst_hit", hit_cnt, 0);
    check("arst_total", total_cnt, 0);
    check("arst_underflow", 32'(underflow), 0);
    check("arst_ready", 32'(pred_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
